// File: rtl/dvi_timing_gen.sv
// Raster timing generator: hsync/vsync/de, pixel coordinates and frame/line strobes for a progressive mode.
// Optional frame counter output enabled by defining DVI_TIMING_GEN_FRAME_CNT_EN.
module dvi_timing_gen #(
  parameter int   H_AV  = 1280,
  parameter int   H_FP  = 110,
  parameter int   H_S   = 40,
  parameter int   H_BP  = 220,
  parameter int   V_AV  = 720,
  parameter int   V_FP  = 5,
  parameter int   V_S   = 5,
  parameter int   V_BP  = 20,
  parameter logic H_POL = 1'b1,
  parameter logic V_POL = 1'b1,
  parameter int   HW    = 12,
  parameter int   VW    = 11,
  parameter int   FCW   = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic          stop,
  output logic          hsync_out,
  output logic          vsync_out,
  output logic          de,
  output logic [HW-1:0] x,
  output logic [VW-1:0] y,
  output logic          frame_start,
  output logic          line_start,
  output logic          running
`ifdef DVI_TIMING_GEN_FRAME_CNT_EN
  ,
  output logic [FCW-1:0] frame_count
`endif
);

  localparam int H_TOT = H_AV + H_FP + H_S + H_BP;
  localparam int V_TOT = V_AV + V_FP + V_S + V_BP;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOT - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_AV);
  localparam logic [HW-1:0] HS_BEG = HW'(H_AV + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_AV + H_FP + H_S);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOT - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_AV);
  localparam logic [VW-1:0] VS_BEG = VW'(V_AV + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_AV + V_FP + V_S);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [HW-1:0] x_q, x_d;
  logic [VW-1:0] y_q, y_d;
  logic          stop_pending_q, stop_pending_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          de_q, de_d;
  logic          frame_start_q, frame_start_d;
  logic          line_start_q, line_start_d;
  logic          line_end;
  logic          frame_end;
  logic          run_d;

  always_comb begin
    state_d        = state_q;
    x_d            = x_q;
    y_d            = y_q;
    stop_pending_d = stop_pending_q;
    line_end       = (x_q == H_LAST);
    frame_end      = line_end && (y_q == V_LAST);

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d        = RUN;
          x_d            = '0;
          y_d            = '0;
          stop_pending_d = 1'b0;
        end
      end
      RUN: begin
        // start cancels a pending stop; a stop on the final pixel still ends this frame
        if (start) begin
          stop_pending_d = 1'b0;
        end else if (stop) begin
          stop_pending_d = 1'b1;
        end
        if (line_end) begin
          x_d = '0;
          if (frame_end) begin
            y_d = '0;
            if (stop_pending_d) begin
              state_d        = IDLE;
              stop_pending_d = 1'b0;
            end
          end else begin
            y_d = y_q + VW'(1);
          end
        end else begin
          x_d = x_q + HW'(1);
        end
      end
      default: begin
        state_d        = IDLE;
        x_d            = '0;
        y_d            = '0;
        stop_pending_d = 1'b0;
      end
    endcase

    // Outputs are decoded from the coordinates that will be shown alongside them.
    run_d         = (state_d == RUN);
    de_d          = run_d && (x_d < H_ACT) && (y_d < V_ACT);
    hsync_d       = (run_d && (x_d >= HS_BEG) && (x_d < HS_END)) ? H_POL : ~H_POL;
    vsync_d       = (run_d && (y_d >= VS_BEG) && (y_d < VS_END)) ? V_POL : ~V_POL;
    frame_start_d = run_d && (x_d == '0) && (y_d == '0);
    line_start_d  = run_d && (x_d == '0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      x_q            <= '0;
      y_q            <= '0;
      stop_pending_q <= 1'b0;
      hsync_q        <= ~H_POL;
      vsync_q        <= ~V_POL;
      de_q           <= 1'b0;
      frame_start_q  <= 1'b0;
      line_start_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      x_q            <= x_d;
      y_q            <= y_d;
      stop_pending_q <= stop_pending_d;
      hsync_q        <= hsync_d;
      vsync_q        <= vsync_d;
      de_q           <= de_d;
      frame_start_q  <= frame_start_d;
      line_start_q   <= line_start_d;
    end
  end

  assign hsync_out   = hsync_q;
  assign vsync_out   = vsync_q;
  assign de          = de_q;
  assign x           = x_q;
  assign y           = y_q;
  assign frame_start = frame_start_q;
  assign line_start  = line_start_q;
  assign running     = (state_q == RUN);

`ifdef DVI_TIMING_GEN_FRAME_CNT_EN
  logic [FCW-1:0] frame_count_q, frame_count_d;

  // Counts the cycle after each frame_start; holds through IDLE, clears only on reset.
  always_comb begin
    frame_count_d = frame_count_q;
    if (frame_start_q) begin
      frame_count_d = frame_count_q + FCW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      frame_count_q <= '0;
    end else begin
      frame_count_q <= frame_count_d;
    end
  end

  assign frame_count = frame_count_q;
`endif

endmodule

// File: tb/tb_dvi_timing_gen.sv
// Bench for dvi_timing_gen in an 8x6 mode: one active-high and one active-low sync instance share stimulus.
module tb_dvi_timing_gen;

  localparam int HW    = 12;
  localparam int VW    = 11;
  localparam int FCW   = 16;
  localparam int H_TOT = 8;
  localparam int V_TOT = 6;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic          stop;

  logic          hs_p, vs_p, de_p, fs_p, ls_p, run_p;
  logic [HW-1:0] x_p;
  logic [VW-1:0] y_p;
  logic          hs_n, vs_n, de_n, fs_n, ls_n, run_n;
  logic [HW-1:0] x_n;
  logic [VW-1:0] y_n;
`ifdef DVI_TIMING_GEN_FRAME_CNT_EN
  logic [FCW-1:0] fc_p, fc_n;
`endif

  logic [47:0] exp_q[$];
  int          checks   = 0;
  int          failures = 0;

  // reference model state: what the DUT should be showing now
  bit          m_run;
  int          mx, my;
  bit          m_pend;
  bit          m_fs;
  logic [15:0] m_fc;

  // clock / reset
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  dvi_timing_gen #(
    .H_AV(4), .H_FP(1), .H_S(2), .H_BP(1),
    .V_AV(3), .V_FP(1), .V_S(1), .V_BP(1),
    .H_POL(1'b1), .V_POL(1'b1), .HW(HW), .VW(VW), .FCW(FCW)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .stop(stop),
    .hsync_out(hs_p), .vsync_out(vs_p), .de(de_p), .x(x_p), .y(y_p),
    .frame_start(fs_p), .line_start(ls_p), .running(run_p)
`ifdef DVI_TIMING_GEN_FRAME_CNT_EN
    , .frame_count(fc_p)
`endif
  );

  dvi_timing_gen #(
    .H_AV(4), .H_FP(1), .H_S(2), .H_BP(1),
    .V_AV(3), .V_FP(1), .V_S(1), .V_BP(1),
    .H_POL(1'b0), .V_POL(1'b0), .HW(HW), .VW(VW), .FCW(FCW)
  ) dut_neg (
    .clock(clock), .reset(reset), .start(start), .stop(stop),
    .hsync_out(hs_n), .vsync_out(vs_n), .de(de_n), .x(x_n), .y(y_n),
    .frame_start(fs_n), .line_start(ls_n), .running(run_n)
`ifdef DVI_TIMING_GEN_FRAME_CNT_EN
    , .frame_count(fc_n)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s: got %0h expected %0h (model x=%0d y=%0d) at %0t", tag, obs, exp, mx, my, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit s, input bit p);
    if (r) begin
      m_run = 0; mx = 0; my = 0; m_pend = 0; m_fc = '0;
    end else begin
      if (m_fs) m_fc = m_fc + 16'd1;
      if (!m_run) begin
        if (s) begin
          m_run = 1; mx = 0; my = 0; m_pend = 0;
        end
      end else begin
        if (s) m_pend = 0;
        else if (p) m_pend = 1;
        if (mx == H_TOT - 1 && my == V_TOT - 1) begin
          mx = 0; my = 0;
          if (m_pend) begin
            m_run = 0; m_pend = 0;
          end
        end else if (mx == H_TOT - 1) begin
          mx = 0; my = my + 1;
        end else begin
          mx = mx + 1;
        end
      end
    end
    m_fs = m_run && mx == 0 && my == 0;
  endtask

  task automatic push_expected();
    bit e_de, e_hs, e_vs, e_ls;
    e_de = m_run && mx < 4 && my < 3;
    e_hs = m_run && mx >= 5 && mx < 7;
    e_vs = m_run && my == 4;
    e_ls = m_run && mx == 0;
    exp_q.push_back({1'b0, m_fc, ~e_hs, ~e_vs, m_run, m_fs, e_ls, e_de, e_hs, e_vs,
                     HW'(mx), VW'(my)});
  endtask

  task automatic compare_cycle();
    logic [47:0] e;
    if (exp_q.size() == 0) begin
      check("queue_empty", 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    check("y",           32'(y_p),   32'(e[10:0]));
    check("x",           32'(x_p),   32'(e[22:11]));
    check("vsync",       32'(vs_p),  32'(e[23]));
    check("hsync",       32'(hs_p),  32'(e[24]));
    check("de",          32'(de_p),  32'(e[25]));
    check("line_start",  32'(ls_p),  32'(e[26]));
    check("frame_start", 32'(fs_p),  32'(e[27]));
    check("running",     32'(run_p), 32'(e[28]));
    check("vsync_neg",   32'(vs_n),  32'(e[29]));
    check("hsync_neg",   32'(hs_n),  32'(e[30]));
    check("x_neg",       32'(x_n),   32'(e[22:11]));
    check("y_neg",       32'(y_n),   32'(e[10:0]));
    check("de_neg",      32'(de_n),  32'(e[25]));
    check("fs_neg",      32'(fs_n),  32'(e[27]));
    check("ls_neg",      32'(ls_n),  32'(e[26]));
    check("run_neg",     32'(run_n), 32'(e[28]));
`ifdef DVI_TIMING_GEN_FRAME_CNT_EN
    check("frame_count",     32'(fc_p), 32'(e[46:31]));
    check("frame_count_neg", 32'(fc_n), 32'(e[46:31]));
`endif
  endtask

  // driver: one clock per call, expectation pushed at the edge, compared on the falling edge
  task automatic step(input bit r, input bit s, input bit p);
    reset = r; start = s; stop = p;
    @(posedge clock);
    model_step(r, s, p);
    push_expected();
    @(negedge clock);
    compare_cycle();
    reset = 1'b0; start = 1'b0; stop = 1'b0;
  endtask

  task automatic run_to(input int tx, input int ty);
    int n;
    n = 0;
    while (!(m_run && mx == tx && my == ty) && n < 200) begin
      step(0, 0, 0);
      n++;
    end
    if (n >= 200) check("run_to_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0;
    m_run = 0; mx = 0; my = 0; m_pend = 0; m_fs = 0; m_fc = '0;

    repeat (3) step(1, 0, 0);
    repeat (20) step(0, 0, 0);

    // free-running frames, then stop mid-frame at (2,1)
    step(0, 1, 0);
    repeat (100) step(0, 0, 0);
    run_to(2, 1);
    step(0, 0, 1);
    repeat (60) step(0, 0, 0);

    // stop cancelled by a later start
    step(0, 1, 0);
    run_to(4, 2);
    step(0, 0, 1);
    repeat (5) step(0, 0, 0);
    step(0, 1, 0);
    repeat (70) step(0, 0, 0);

    // reset mid-frame, then restart
    run_to(3, 2);
    step(1, 0, 0);
    repeat (5) step(0, 0, 0);
    step(0, 1, 0);
    repeat (20) step(0, 0, 0);

    // stop on the final pixel
    run_to(H_TOT - 1, V_TOT - 1);
    step(0, 0, 1);
    repeat (10) step(0, 0, 0);

    // start and stop together in IDLE: runs with no pending stop
    step(0, 1, 1);
    repeat (100) step(0, 0, 0);

    // random control traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 99) < 2,
           $urandom_range(0, 99) < 3);
    end
    step(0, 0, 1);
    repeat (60) step(0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
